// File: rtl/mux_arb_pkg.sv
// Shared constants for the arbitrated multiplexer and its grant logic.
package mux_arb_pkg;

    localparam logic ARB_RR    = 1'b0;
    localparam logic ARB_FIXED = 1'b1;

endpackage

// File: rtl/arb_rr_n.sv
// Combinational grant logic: forced select, fixed priority or round-robin
// from a pointer; produces a one-hot grant plus its encoded index.
module arb_rr_n
    import mux_arb_pkg::*;
#(
    parameter  int N_CH  = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             mode,
    input  logic             force_en,
    input  logic [SEL_W-1:0] force_sel,
    output logic [N_CH-1:0]  grant,
    output logic [SEL_W-1:0] grant_idx,
    output logic             grant_any
);

    int best_dist;

    // Distance from the pointer to channel ch walking upward with wrap.
    function automatic int rr_dist(input int ch, input logic [SEL_W-1:0] p);
        int pv;
        pv = int'(p);
        return (ch >= pv) ? (ch - pv) : (ch + N_CH - pv);
    endfunction

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        best_dist = N_CH;
        if (force_en) begin
            for (int i = 0; i < N_CH; i++) begin
                if (SEL_W'(i) == force_sel && req[i]) begin
                    grant[i]  = 1'b1;
                    grant_idx = SEL_W'(i);
                    grant_any = 1'b1;
                end
            end
        end else if (mode == ARB_FIXED) begin
            // Descending scan so the lowest requesting index is written last.
            for (int i = N_CH - 1; i >= 0; i--) begin
                if (req[i]) begin
                    grant     = '0;
                    grant[i]  = 1'b1;
                    grant_idx = SEL_W'(i);
                    grant_any = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (req[i] && rr_dist(i, ptr) < best_dist) begin
                    best_dist = rr_dist(i, ptr);
                    grant     = '0;
                    grant[i]  = 1'b1;
                    grant_idx = SEL_W'(i);
                    grant_any = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mux_arb_n.sv
// N-channel arbitrated multiplexer with valid/ready handshakes on both sides
// and a single registered output slot.
module mux_arb_n
    import mux_arb_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N_CH  = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [N_CH*WIDTH-1:0] In_Data,
    input  logic [N_CH-1:0]       In_Valid,
    output logic [N_CH-1:0]       In_Ready,
    input  logic                  Arb_Mode,
    input  logic                  Force_En,
    input  logic [SEL_W-1:0]      Force_Sel,
    output logic [WIDTH-1:0]      Out_Data,
    output logic [SEL_W-1:0]      Out_Sel,
    output logic                  Out_Valid,
    input  logic                  Out_Ready
);

    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic             out_valid_q, out_valid_d;

    logic [N_CH-1:0]  grant;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_any;
    logic             load_en;
    logic [WIDTH-1:0] sel_data;

    arb_rr_n #(
        .N_CH (N_CH)
    ) u_arb (
        .req       (In_Valid),
        .ptr       (ptr_q),
        .mode      (Arb_Mode),
        .force_en  (Force_En),
        .force_sel (Force_Sel),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // The slot can take a new word when empty or being drained this cycle.
    assign load_en  = !out_valid_q || Out_Ready;
    assign In_Ready = grant & {N_CH{load_en && !Reset}};

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                sel_data = In_Data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            if (grant_any) begin
                out_data_d  = sel_data;
                out_sel_d   = grant_idx;
                out_valid_d = 1'b1;
                // Only round-robin transfers rotate the pointer.
                if (!Force_En && Arb_Mode == ARB_RR) begin
                    ptr_d = (grant_idx == SEL_W'(N_CH - 1)) ? '0 : grant_idx + SEL_W'(1);
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ptr_q       <= '0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign Out_Data  = out_data_q;
    assign Out_Sel   = out_sel_q;
    assign Out_Valid = out_valid_q;

endmodule

// File: doc/mux_arb_n.md
# mux_arb_n

Parametrised N-channel, WIDTH-bit arbitrated multiplexer with valid/ready handshakes and a registered output stage; successor to the plain 2-to-1 selector. Selects one requesting channel per cycle using round-robin or fixed-priority arbitration, or a forced select, and holds the result until the consumer accepts it. Sits between multiple producers (e.g. writeback sources, memory request ports) and a single consumer in the RISC-V datapath.

## Interface
- WIDTH, 32, data width per channel
- N_CH, 4, number of input channels (2..16)
- SEL_W, $clog2(N_CH), width of channel index (derived, not overridden)

- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- In_Data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- In_Valid  input  N_CH  channel i request
- In_Ready  output  N_CH  channel i accepted this cycle (combinational)
- Arb_Mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins)
- Force_En  input  1  1 = ignore arbitration, use Force_Sel only
- Force_Sel  input  SEL_W  forced channel index
- Out_Data  output  WIDTH  registered selected data
- Out_Sel  output  SEL_W  registered index of channel that produced Out_Data
- Out_Valid  output  1  Out_Data holds an unconsumed word
- Out_Ready  input  1  consumer accepts Out_Data when Out_Valid & Out_Ready

## Operation
- Reset: Out_Valid=0, Out_Data=0, Out_Sel=0, RR pointer=0; In_Ready=0 while Reset high.
- Load_En = !Out_Valid | Out_Ready (output slot free or draining this cycle).
- Grant (one-hot, at most one bit) computed each cycle:
  - Force_En=1: grant Force_Sel iff In_Valid[Force_Sel]; Force_Sel >= N_CH grants nothing.
  - Arb_Mode=1: lowest-index valid channel.
  - Arb_Mode=0: first valid channel at or after RR pointer, wrapping N_CH-1 -> 0.
- In_Ready[i] = Grant[i] & Load_En & !Reset.
- On a clock edge with Load_En:
  - any grant: Out_Data<=In_Data[g], Out_Sel<=g, Out_Valid<=1.
  - no grant: Out_Valid<=0; Out_Data, Out_Sel hold.
- Without Load_En: all outputs hold (stall), no In_Ready asserted.
- RR pointer updates to (g+1) mod N_CH only on an accepted transfer in round-robin mode; fixed-priority and forced transfers leave it unchanged.
- Mode/Force changes take effect on the next grant computation; a word already in the output register is unaffected.

## Timing
- Latency: input accepted on edge k appears on Out_Data/Out_Valid after edge k.
- Throughput: one word per cycle when Out_Ready held high.
- Simultaneous drain and load: Out_Ready=1 with Out_Valid=1 and a valid requester → new word replaces old on same edge, Out_Valid stays 1.
- Backpressure: Out_Valid=1, Out_Ready=0 → Out_Data stable every cycle until accepted.
- Reset mid-transfer: asynchronous clear of Out_Valid and pointer immediately; pending word discarded.
- In_Valid must not be withdrawn by producers while waiting (AXI-style rule); the block does not depend on it.

## Structure
- Shared package mux_arb_pkg: ARB_RR=1'b0, ARB_FIXED=1'b1 constants.
- Sub-module arb_rr_n: combinational grant logic (requests, pointer, mode, force → one-hot grant + encoded index); mux_arb_n holds pointer, output register and handshake.

## Test plan
- Reset with In_Valid=4'b1111 → Out_Valid=0, Out_Data=0, In_Ready=0; after release, first grant ch0, Out_Data=In_Data[0] one cycle later.
- RR, N_CH=4, all valid, Out_Ready=1, In_Data[i]=100+i → Out_Sel sequence 0,1,2,3,0, Out_Data 100,101,102,103,100.
- Fixed priority, In_Valid=4'b1010 → Out_Sel=1 every cycle; ch3 never granted while ch1 valid.
- Backpressure: Out_Valid=1 with Out_Data=32'd3000000, Out_Ready=0 for 3 cycles → Out_Data constant, In_Ready=0; Out_Ready=1 → next word loaded same edge.
- Force_En=1, Force_Sel=2, In_Valid=4'b0001 → no grant, Out_Valid drops to 0; set In_Valid[2] with In_Data[2]=32'd5254513 → Out_Data=5254513, Out_Sel=2, RR pointer unchanged.
- Reset asserted mid-stream while Out_Valid=1 → Out_Valid=0 immediately (before next edge); next grant after release is ch0.
